// File: rtl/csr_access_ctrl_pkg.sv
// csr_pkg: shared types and constants for the CSR access sequencer
package csr_pkg;
    localparam int XLEN_DEF = 32;
    localparam int SEL_W_DEF = 4;
    localparam logic [15:0] RO_MASK_DEF = 16'h0707;
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_e;
    localparam logic [1:0] CSR_R = 2'b00;
    localparam logic [1:0] CSR_RW = 2'b01;
    localparam logic [1:0] CSR_RS = 2'b10;
    localparam logic [1:0] CSR_RC = 2'b11;
    localparam int SEL_CYCLE = 0;
    localparam int SEL_TIME = 1;
    localparam int SEL_INSTRET = 2;
    localparam int SEL_CYCLEH = 8;
    localparam int SEL_TIMEH = 9;
    localparam int SEL_INSTRETH = 10;
endpackage

// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: decode-side request/response and bank-side signals
interface csr_access_ctrl_if #(parameter int XLEN = 32, parameter int SEL_W = 4);
    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_sel;
    logic [1:0]       req_mode;
    logic             req_rd_en;
    logic [XLEN-1:0]  req_wdata;
    logic             resp_valid;
    logic [XLEN-1:0]  resp_rdata;
    logic             resp_err;
    logic             busy;
    logic [SEL_W-1:0] bank_sel;
    logic             bank_re;
    logic [XLEN-1:0]  bank_rdata;
    logic             bank_we;
    logic [XLEN-1:0]  bank_wdata;
    modport master (
        output req_valid, req_sel, req_mode, req_rd_en, req_wdata, bank_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy, bank_sel, bank_re, bank_we, bank_wdata
    );
    modport slave (
        input  req_valid, req_sel, req_mode, req_rd_en, req_wdata, bank_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy, bank_sel, bank_re, bank_we, bank_wdata
    );
endinterface

// File: rtl/csr_access_ctrl_rmw_alu.sv
// csr_rmw_alu: new CSR value from mode, old value and operand
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [1:0]      mode_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] operand_i,
    output logic [XLEN-1:0] new_o
);
    // write replaces, set ORs in, clear masks out; plain read keeps old
    always_comb
        new_o = mode_i == CSR_RW ? operand_i :
                mode_i == CSR_RS ? (old_i | operand_i) :
                mode_i == CSR_RC ? (old_i & ~operand_i) : old_i;
endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences CSR read / write / set / clear onto a single-port bank
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int SEL_W = SEL_W_DEF,
    parameter logic [(1<<SEL_W)-1:0] RO_MASK = RO_MASK_DEF
) (
    input logic clk,
    input logic reset,
    csr_access_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q;
    logic [1:0]       mode_q;
    logic             rd_en_q, illegal_q;
    logic [XLEN-1:0]  wdata_q, old_q, new_val;
    logic             accept, acc_illegal, acc_need_rd;

    assign accept = state_q == IDLE && bus.req_valid;
    assign acc_illegal = bus.req_mode != CSR_R && RO_MASK[bus.req_sel];
    assign acc_need_rd = bus.req_rd_en || bus.req_mode[1];

    csr_rmw_alu #(.XLEN(XLEN)) u_alu (
        .mode_i(mode_q),
        .old_i(old_q),
        .operand_i(wdata_q),
        .new_o(new_val)
    );

    // state register; reset aborts any sequence in flight
    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else state_q <= state_d;

    // next-state: shortest path through RD/CAP/WR that the request needs
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req_valid)
                state_d = acc_illegal ? RESP : acc_need_rd ? RD : bus.req_mode != CSR_R ? WR : RESP;
            RD:   state_d = CAP;
            CAP:  state_d = mode_q == CSR_R ? RESP : WR;
            WR:   state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // request latch on accept; old value captured one cycle after the bank read
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sel_q <= '0;
            mode_q <= CSR_R;
            rd_en_q <= 1'b0;
            illegal_q <= 1'b0;
            wdata_q <= '0;
            old_q <= '0;
        end else if (accept) begin
            sel_q <= bus.req_sel;
            mode_q <= bus.req_mode;
            rd_en_q <= bus.req_rd_en;
            illegal_q <= acc_illegal;
            wdata_q <= bus.req_wdata;
            old_q <= '0;
        end else if (state_q == CAP) begin
            old_q <= bus.bank_rdata;
        end

    // outputs decoded from state; data buses are zero unless strobed/valid
    always_comb begin
        bus.req_ready = state_q == IDLE && !reset;
        bus.busy = state_q != IDLE;
        bus.bank_re = state_q == RD;
        bus.bank_we = state_q == WR;
        bus.bank_sel = (state_q == RD || state_q == CAP || state_q == WR) ? sel_q : '0;
        bus.bank_wdata = state_q == WR ? new_val : '0;
        bus.resp_valid = state_q == RESP;
        bus.resp_rdata = (state_q == RESP && rd_en_q) ? old_q : '0;
        bus.resp_err = state_q == RESP && illegal_q;
    end
endmodule
